// File: rtl/z80_bus_pkg.sv
// Shared Z80 bus structures: the master-side drive bundle and the slave-side response bundle.
package z80_bus_pkg;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  dmaster;
        logic        mreqn;
        logic        iorqn;
        logic        rdn;
        logic        wrn;
        logic        m1n;
        logic        rfshn;
        logic        busackn;
        logic        haltn;
    } Z80MasterBus;

    typedef struct packed {
        logic       mwait;
        logic [7:0] dslave;
    } Z80SlaveBus;

endpackage

// File: rtl/z80_serial_pkg.sv
// Command FSM states and byte-level protocol constants for the UART-driven Z80 bus master.
package z80_serial_pkg;

    typedef enum logic [2:0] {
        IDLE,
        AHI,
        ALO,
        DATA,
        REQ,
        BUS,
        RESP
    } state_t;

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] RSP_ACK  = 8'h2E;
    localparam logic [7:0] RSP_ERR  = 8'h3F;

endpackage

// File: rtl/z80_serial_master.sv
// UART-command-driven Z80 bus master: 'W' a a d / 'R' a a -> one memory cycle, one response byte.
// Last rx_dv to tx_dv is BUS_MIN_CYCLES+3 clocks when granted and idle; stalls on bus_gnt low and tx_busy high.
module z80_serial_master
    import z80_bus_pkg::*;
    import z80_serial_pkg::*;
#(
    parameter int BUS_MIN_CYCLES = 2,
    parameter int TIMEOUT_CLKS   = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_dv,
    input  logic [7:0]  rx_byte,
    output logic        tx_dv,
    output logic [7:0]  tx_byte,
    input  logic        tx_busy,
    output logic        bus_req,
    input  logic        bus_gnt,
    output Z80MasterBus obus,
    input  Z80SlaveBus  ibus
);

    localparam int         TW      = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CLKS - 1);
    localparam logic [3:0] BMC     = 4'(BUS_MIN_CYCLES);

    state_t          state;
    logic            is_write;
    logic [15:0]     addr;
    logic [7:0]      dmaster;
    logic            mreqn;
    logic            rdn;
    logic            wrn;
    logic [3:0]      bcnt;
    logic [TW-1:0]   tcnt;

    always_comb begin
        obus         = '1;
        obus.addr    = addr;
        obus.dmaster = dmaster;
        obus.mreqn   = mreqn;
        obus.rdn     = rdn;
        obus.wrn     = wrn;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            is_write <= 1'b0;
            addr     <= '0;
            dmaster  <= '0;
            mreqn    <= 1'b1;
            rdn      <= 1'b1;
            wrn      <= 1'b1;
            bcnt     <= '0;
            tcnt     <= '0;
            tx_dv    <= 1'b0;
            tx_byte  <= '0;
            bus_req  <= 1'b0;
        end else begin
            tx_dv <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_dv) begin
                        is_write <= (rx_byte == OP_WRITE);
                        tcnt     <= '0;
                        if (rx_byte == OP_WRITE || rx_byte == OP_READ) begin
                            state <= AHI;
                        end else begin
                            tx_byte <= RSP_ERR;
                            state   <= RESP;
                        end
                    end
                end

                // Inter-byte timeout only guards command collection; rx_dv beats expiry.
                AHI, ALO, DATA: begin
                    if (rx_dv) begin
                        tcnt <= '0;
                        if (state == AHI) begin
                            addr[15:8] <= rx_byte;
                            state      <= ALO;
                        end else if (state == ALO) begin
                            addr[7:0] <= rx_byte;
                            if (is_write) begin
                                state <= DATA;
                            end else begin
                                bus_req <= 1'b1;
                                state   <= REQ;
                            end
                        end else begin
                            dmaster <= rx_byte;
                            bus_req <= 1'b1;
                            state   <= REQ;
                        end
                    end else if (tcnt == TO_LAST) begin
                        tcnt  <= '0;
                        state <= IDLE;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end

                REQ: begin
                    if (bus_gnt) begin
                        mreqn <= 1'b0;
                        rdn   <= is_write;
                        wrn   <= ~is_write;
                        bcnt  <= 4'd1;
                        state <= BUS;
                    end
                end

                // Grant is not re-checked here: the arbiter never revokes mid-cycle.
                BUS: begin
                    if (bcnt >= BMC && ibus.mwait) begin
                        mreqn   <= 1'b1;
                        rdn     <= 1'b1;
                        wrn     <= 1'b1;
                        bus_req <= 1'b0;
                        tx_byte <= is_write ? RSP_ACK : ibus.dslave;
                        state   <= RESP;
                    end else if (bcnt != 4'hF) begin
                        bcnt <= bcnt + 4'd1;
                    end
                end

                RESP: begin
                    if (!tx_busy) begin
                        tx_dv <= 1'b1;
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_z80_serial_master.sv
// Scoreboard bench for z80_serial_master: expected bus cycles and response bytes are queued at stimulus time.
module tb_z80_serial_master;
    import z80_bus_pkg::*;

    localparam int BMC = 2;
    localparam int TO  = 16;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  dat;
        bit          wr;
        int          len;
    } bus_exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_dv = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        tx_dv;
    logic [7:0]  tx_byte;
    logic        tx_busy = 1'b0;
    logic        bus_req;
    logic        bus_gnt = 1'b1;
    Z80MasterBus obus;
    Z80SlaveBus  ibus;
    logic        mwait = 1'b1;
    logic [7:0]  dslave = 8'h00;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int last_rx_cyc = 0;
    int wait_clks = 0;
    bit lat_chk = 1'b0;
    int req_cycles = 0;
    int n_tx = 0;
    int n_strobe = 0;
    bit in_strobe = 1'b0;
    bit prev_txdv = 1'b0;
    int s_len;
    logic [15:0] s_addr;
    logic [7:0]  s_dat;
    bit s_rd, s_wr, s_moved;

    logic [7:0] tx_q[$];
    bus_exp_t   bus_q[$];

    assign ibus = '{mwait: mwait, dslave: dslave};

    z80_serial_master #(
        .BUS_MIN_CYCLES(BMC),
        .TIMEOUT_CLKS(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx_dv(rx_dv),
        .rx_byte(rx_byte),
        .tx_dv(tx_dv),
        .tx_byte(tx_byte),
        .tx_busy(tx_busy),
        .bus_req(bus_req),
        .bus_gnt(bus_gnt),
        .obus(obus),
        .ibus(ibus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp)
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        else
            n_pass++;
    endtask

    function automatic int exp_len(input int w);
        return (w + 1 > BMC) ? w + 1 : BMC;
    endfunction

    // Monitor: response bytes, strobe shape, and the slave's wait-state model.
    always @(negedge clk) begin
        bus_exp_t e;
        logic [7:0] t;
        if (bus_req) req_cycles++;
        if (tx_dv) begin
            n_tx++;
            chk("tx_single", prev_txdv, 1'b0);
            if (tx_q.size() == 0) begin
                chk("tx_unexpected", tx_dv, 1'b0);
            end else begin
                t = tx_q.pop_front();
                chk("tx_byte", tx_byte, t);
                if (lat_chk) chk("latency", cyc - last_rx_cyc, BMC + 3);
            end
        end
        prev_txdv = tx_dv;

        if (!obus.mreqn) begin
            if (!in_strobe) begin
                in_strobe = 1'b1;
                n_strobe++;
                s_len   = 0;
                s_addr  = obus.addr;
                s_dat   = obus.dmaster;
                s_rd    = !obus.rdn;
                s_wr    = !obus.wrn;
                s_moved = 1'b0;
            end
            s_len++;
            if (obus.addr != s_addr || obus.dmaster != s_dat) s_moved = 1'b1;
            mwait = (s_len > wait_clks);
        end else if (in_strobe) begin
            in_strobe = 1'b0;
            mwait = 1'b1;
            if (!rst) begin
                if (bus_q.size() == 0) begin
                    chk("bus_unexpected", s_len, 0);
                end else begin
                    e = bus_q.pop_front();
                    chk("bus_addr", s_addr, e.addr);
                    chk("bus_kind", {s_rd, s_wr}, {!e.wr, e.wr});
                    chk("bus_len", s_len, e.len);
                    chk("bus_stable", s_moved, 1'b0);
                    if (e.wr) chk("bus_dat", s_dat, e.dat);
                end
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_byte = b;
        rx_dv = 1'b1;
        last_rx_cyc = cyc;
        @(negedge clk);
        rx_dv = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (tx_q.size() == 0 && bus_q.size() == 0 && !in_strobe) break;
            @(negedge clk);
        end
        chk("drain", tx_q.size() + bus_q.size(), 0);
        tick(3);
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] d);
        bus_q.push_back('{addr: a, dat: d, wr: 1'b1, len: exp_len(wait_clks)});
        tx_q.push_back(8'h2E);
        send(8'h57);
        send(a[15:8]);
        send(a[7:0]);
        send(d);
    endtask

    task automatic do_read(input logic [15:0] a, input logic [7:0] d);
        dslave = d;
        bus_q.push_back('{addr: a, dat: 8'h00, wr: 1'b0, len: exp_len(wait_clks)});
        tx_q.push_back(d);
        send(8'h52);
        send(a[15:8]);
        send(a[7:0]);
    endtask

    initial begin
        int snap;
        int snap2;
        tick(3);
        chk("rst_tx_dv", tx_dv, 1'b0);
        chk("rst_tx_byte", tx_byte, 8'h00);
        chk("rst_bus_req", bus_req, 1'b0);
        chk("rst_strobes", {obus.mreqn, obus.rdn, obus.wrn}, 3'b111);
        chk("rst_addr", obus.addr, 16'h0000);
        chk("rst_dmaster", obus.dmaster, 8'h00);
        chk("rst_idle_fields", {obus.iorqn, obus.m1n, obus.rfshn, obus.busackn, obus.haltn}, 5'h1F);
        rst = 1'b0;
        tick(2);

        // Plain write, grant tied high, no wait states.
        lat_chk = 1'b1;
        do_write(16'h1234, 8'hA5);
        wait_done(60);
        lat_chk = 1'b0;

        // Read stretched by five wait clocks.
        wait_clks = 5;
        do_read(16'h8000, 8'h3C);
        wait_done(60);
        wait_clks = 0;

        // Unknown opcode, then a normal read.
        snap = req_cycles;
        tx_q.push_back(8'h3F);
        send(8'h41);
        wait_done(30);
        chk("bad_no_req", req_cycles - snap, 0);
        do_read(16'h55AA, 8'h96);
        wait_done(60);

        // Abandoned command times out silently; next full write is decoded afresh.
        snap = req_cycles;
        snap2 = n_tx;
        send(8'h57);
        send(8'h12);
        tick(TO + 4);
        chk("to_no_req", req_cycles - snap, 0);
        chk("to_no_tx", n_tx - snap2, 0);
        do_write(16'hABCD, 8'h5A);
        wait_done(60);

        // A long inter-byte gap still under the limit keeps the command alive.
        bus_q.push_back('{addr: 16'h5678, dat: 8'h9A, wr: 1'b1, len: BMC});
        tx_q.push_back(8'h2E);
        send(8'h57);
        tick(TO - 3);
        send(8'h56);
        send(8'h78);
        send(8'h9A);
        wait_done(60);

        // Grant withheld, then response held off by a busy transmitter.
        bus_gnt = 1'b0;
        do_read(16'h0102, 8'hC3);
        for (int i = 0; i < 20 && !bus_req; i++) @(negedge clk);
        snap = n_strobe;
        tick(20);
        chk("no_strobe_wo_gnt", n_strobe - snap, 0);
        chk("req_held", bus_req, 1'b1);
        tx_busy = 1'b1;
        bus_gnt = 1'b1;
        for (int i = 0; i < 20 && (bus_q.size() != 0 || in_strobe); i++) @(negedge clk);
        snap = n_tx;
        tick(10);
        chk("tx_held", n_tx - snap, 0);
        chk("tx_hold_byte", tx_byte, 8'hC3);
        tx_busy = 1'b0;
        wait_done(30);

        // Reset in the middle of a read strobe.
        wait_clks = 20;
        send(8'h52);
        send(8'h40);
        send(8'h00);
        for (int i = 0; i < 20 && obus.rdn; i++) @(negedge clk);
        chk("rd_started", obus.rdn, 1'b0);
        tick(2);
        rst = 1'b1;
        #1;
        chk("rst_mid_rdn", obus.rdn, 1'b1);
        chk("rst_mid_mreqn", obus.mreqn, 1'b1);
        chk("rst_mid_req", bus_req, 1'b0);
        tick(3);
        rst = 1'b0;
        wait_clks = 0;
        snap = n_tx;
        tick(30);
        chk("rst_no_tx", n_tx - snap, 0);
        do_write(16'hFFFF, 8'h00);
        wait_done(60);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
